// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
// Holds bus widths, stall and boolean encodings, the NOP word, the opcodes
// the predictor decodes, the BHT geometry, the fetch FSM state type, and
// the immediate decoders for B-type and JAL.
package if_fetch_pkg;

    localparam int STALL_BUS_W = 6;
    typedef logic [STALL_BUS_W-1:0] stall_bus_t;
    typedef logic [31:0]            inst_addr_bus_t;
    typedef logic [31:0]            reg_bus_t;

    localparam logic TRUE    = 1'b1;
    localparam logic FALSE   = 1'b0;
    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    // StallBus bit positions
    localparam int STALL_PC = 0;
    localparam int STALL_IF = 1;

    localparam reg_bus_t INST_NOP = 32'h0000_0013;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam int BHT_IDX_W   = 6;
    localparam int BHT_ENTRIES = 1 << BHT_IDX_W;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_t;

    function automatic reg_bus_t imm_b(input reg_bus_t inst);
        return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

    function automatic reg_bus_t imm_j(input reg_bus_t inst);
        return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/if_bht.sv
// Branch history table: 64 two-bit saturating counters.
// Ports:
//   clk, rst        clock, synchronous active-high reset (counters -> 01)
//   upd_i           update strobe from EX
//   upd_idx_i       counter index to update
//   upd_taken_i     resolved direction (1 = increment, 0 = decrement)
//   lookup_idx_i    counter index to read
//   lookup_taken_o  MSB of the addressed counter (predict taken)
// The lookup reads the registered counters, so an update to the same index
// in the same cycle is not visible until the following cycle.
module if_bht
    import if_fetch_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 upd_i,
    input  logic [BHT_IDX_W-1:0] upd_idx_i,
    input  logic                 upd_taken_i,
    input  logic [BHT_IDX_W-1:0] lookup_idx_i,
    output logic                 lookup_taken_o
);

    logic [1:0] cnt_q [BHT_ENTRIES];
    logic [1:0] cnt_d [BHT_ENTRIES];

    always_comb begin
        for (int i = 0; i < BHT_ENTRIES; i++) begin
            cnt_d[i] = cnt_q[i];
            if (upd_i && (upd_idx_i == BHT_IDX_W'(i))) begin
                if (upd_taken_i) begin
                    if (cnt_q[i] != 2'b11) cnt_d[i] = cnt_q[i] + 2'd1;
                end else begin
                    if (cnt_q[i] != 2'b00) cnt_d[i] = cnt_q[i] - 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) cnt_q[i] <= 2'b01;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign lookup_taken_o = cnt_q[lookup_idx_i][1];

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage with static JAL / BHT-based branch prediction.
// Issues one fetch at a time to the memory controller, predicts the next PC
// from the returned word, and presents the instruction to decode through an
// output register backed by a one-entry skid buffer for IF holds.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   stall_i[5:0]                  StallBus: bit0 holds PC, bit1 holds IF outputs
//   ex_jmp_wrong_i/_target_i      misprediction redirect from EX
//   ex_br_upd_i/_pc_i/_taken_i    resolved branch, trains the BHT
//   mem_req_o/mem_addr_o          fetch request, held until mem_done_i
//   mem_done_i/mem_data_i         one-cycle completion with the fetched word
//   if_pc_o/if_inst_o             delivered instruction (NOP when none)
//   if_jmp_status_o/if_offset_o   predicted-taken flag and B/JAL immediate
//   stallreq_o                    pipeline stall request while a fetch is open
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | no fetch outstanding; issues the next one when allowed
// ST_BUSY    | fetch outstanding; its data will be delivered
// ST_DISCARD | fetch outstanding after a redirect; its data will be dropped
module if_fetch
    import if_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall_i,
    input  logic        ex_jmp_wrong_i,
    input  logic [31:0] ex_jmp_target_i,
    input  logic        ex_br_upd_i,
    input  logic [31:0] ex_br_pc_i,
    input  logic        ex_br_taken_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_done_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_inst_o,
    output logic        if_jmp_status_o,
    output logic [31:0] if_offset_o,
    output logic        stallreq_o
);

    fetch_state_t   state_q, state_d;
    inst_addr_bus_t pc_q, pc_d;
    logic           mem_req_q, mem_req_d;
    inst_addr_bus_t mem_addr_q, mem_addr_d;

    inst_addr_bus_t out_pc_q, out_pc_d;
    reg_bus_t       out_inst_q, out_inst_d;
    logic           out_taken_q, out_taken_d;
    reg_bus_t       out_offset_q, out_offset_d;

    logic           buf_valid_q, buf_valid_d;
    inst_addr_bus_t buf_pc_q, buf_pc_d;
    reg_bus_t       buf_inst_q, buf_inst_d;
    logic           buf_taken_q, buf_taken_d;
    reg_bus_t       buf_offset_q, buf_offset_d;

    logic           unused_inputs;
    assign unused_inputs = ^{stall_i[5:2], ex_br_pc_i[31:8], ex_br_pc_i[1:0]};

    // Decode of the word returning from memory; its PC is the request address.
    logic           bht_taken;
    logic           fetch_is_jal;
    logic           fetch_is_br;
    logic           fetch_taken;
    reg_bus_t       fetch_offset;
    inst_addr_bus_t fetch_next_pc;
    logic           fetch_ok;

    if_bht u_bht (
        .clk            (clk),
        .rst            (rst),
        .upd_i          (ex_br_upd_i),
        .upd_idx_i      (ex_br_pc_i[7:2]),
        .upd_taken_i    (ex_br_taken_i),
        .lookup_idx_i   (mem_addr_q[7:2]),
        .lookup_taken_o (bht_taken)
    );

    always_comb begin
        fetch_is_jal  = (mem_data_i[6:0] == OPC_JAL);
        fetch_is_br   = (mem_data_i[6:0] == OPC_BRANCH);
        fetch_offset  = fetch_is_jal ? imm_j(mem_data_i) :
                        fetch_is_br  ? imm_b(mem_data_i) : '0;
        fetch_taken   = fetch_is_jal || (fetch_is_br && bht_taken);
        fetch_next_pc = fetch_taken ? (mem_addr_q + fetch_offset)
                                    : (mem_addr_q + 32'd4);
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        out_pc_d     = out_pc_q;
        out_inst_d   = out_inst_q;
        out_taken_d  = out_taken_q;
        out_offset_d = out_offset_q;
        buf_valid_d  = buf_valid_q;
        buf_pc_d     = buf_pc_q;
        buf_inst_d   = buf_inst_q;
        buf_taken_d  = buf_taken_q;
        buf_offset_d = buf_offset_q;
        fetch_ok     = FALSE;

        case (state_q)
            ST_IDLE: begin
                if (ex_jmp_wrong_i) begin
                    pc_d = ex_jmp_target_i;
                end else if (stall_i[STALL_PC] == NO_STOP && !buf_valid_q) begin
                    mem_req_d  = TRUE;
                    mem_addr_d = pc_q & ~32'h3;
                    state_d    = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (ex_jmp_wrong_i) begin
                    pc_d = ex_jmp_target_i;
                    if (mem_done_i) begin
                        mem_req_d = FALSE;
                        state_d   = ST_IDLE;
                    end else begin
                        state_d   = ST_DISCARD;
                    end
                end else if (mem_done_i) begin
                    // The predicted PC is taken even under a PC hold; the hold
                    // only prevents the next request from going out.
                    mem_req_d = FALSE;
                    state_d   = ST_IDLE;
                    pc_d      = fetch_next_pc;
                    fetch_ok  = TRUE;
                end
            end
            ST_DISCARD: begin
                if (ex_jmp_wrong_i) pc_d = ex_jmp_target_i;
                if (mem_done_i) begin
                    mem_req_d = FALSE;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                mem_req_d = FALSE;
                state_d   = ST_IDLE;
            end
        endcase

        // A redirect flushes wrong-path work even through an IF hold.
        if (ex_jmp_wrong_i) begin
            out_inst_d   = INST_NOP;
            out_taken_d  = FALSE;
            out_offset_d = '0;
            buf_valid_d  = FALSE;
        end else if (stall_i[STALL_IF] == STOP) begin
            if (fetch_ok) begin
                buf_valid_d  = TRUE;
                buf_pc_d     = mem_addr_q;
                buf_inst_d   = mem_data_i;
                buf_taken_d  = fetch_taken;
                buf_offset_d = fetch_offset;
            end
        end else if (buf_valid_q) begin
            out_pc_d     = buf_pc_q;
            out_inst_d   = buf_inst_q;
            out_taken_d  = buf_taken_q;
            out_offset_d = buf_offset_q;
            buf_valid_d  = FALSE;
        end else if (fetch_ok) begin
            out_pc_d     = mem_addr_q;
            out_inst_d   = mem_data_i;
            out_taken_d  = fetch_taken;
            out_offset_d = fetch_offset;
        end else begin
            // Bubble: an instruction is presented for exactly one cycle.
            out_inst_d   = INST_NOP;
            out_taken_d  = FALSE;
            out_offset_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pc_q         <= '0;
            mem_req_q    <= FALSE;
            mem_addr_q   <= '0;
            out_pc_q     <= '0;
            out_inst_q   <= INST_NOP;
            out_taken_q  <= FALSE;
            out_offset_q <= '0;
            buf_valid_q  <= FALSE;
            buf_pc_q     <= '0;
            buf_inst_q   <= INST_NOP;
            buf_taken_q  <= FALSE;
            buf_offset_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            out_pc_q     <= out_pc_d;
            out_inst_q   <= out_inst_d;
            out_taken_q  <= out_taken_d;
            out_offset_q <= out_offset_d;
            buf_valid_q  <= buf_valid_d;
            buf_pc_q     <= buf_pc_d;
            buf_inst_q   <= buf_inst_d;
            buf_taken_q  <= buf_taken_d;
            buf_offset_q <= buf_offset_d;
        end
    end

    // Drops in the completion cycle so the pipeline can advance with the data.
    assign stallreq_o      = (state_q == ST_DISCARD) ||
                             (state_q == ST_BUSY && !mem_done_i);
    assign mem_req_o       = mem_req_q;
    assign mem_addr_o      = mem_addr_q;
    assign if_pc_o         = out_pc_q;
    assign if_inst_o       = out_inst_q;
    assign if_jmp_status_o = out_taken_q;
    assign if_offset_o     = out_offset_q;

endmodule

// File: tb/tb_if_fetch.sv
// Directed testbench for if_fetch. Memory responses are driven by hand so
// that completions can be lined up with stalls and redirects.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall_i;
    logic        ex_jmp_wrong_i;
    logic [31:0] ex_jmp_target_i;
    logic        ex_br_upd_i;
    logic [31:0] ex_br_pc_i;
    logic        ex_br_taken_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_done_i;
    logic [31:0] mem_data_i;
    logic [31:0] if_pc_o;
    logic [31:0] if_inst_o;
    logic        if_jmp_status_o;
    logic [31:0] if_offset_o;
    logic        stallreq_o;

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] JAL16 = 32'h0100_006F;  // jal x0, +16
    localparam logic [31:0] BEQ8  = 32'h0000_0463;  // beq x0,x0,+8
    localparam logic [31:0] BEQ32 = 32'h0200_0063;  // beq x0,x0,+32
    localparam logic [31:0] ADDI  = 32'h0010_0093;  // addi x1,x0,1

    int n_cmp = 0;
    int n_err = 0;

    if_fetch dut (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (stall_i),
        .ex_jmp_wrong_i  (ex_jmp_wrong_i),
        .ex_jmp_target_i (ex_jmp_target_i),
        .ex_br_upd_i     (ex_br_upd_i),
        .ex_br_pc_i      (ex_br_pc_i),
        .ex_br_taken_i   (ex_br_taken_i),
        .mem_req_o       (mem_req_o),
        .mem_addr_o      (mem_addr_o),
        .mem_done_i      (mem_done_i),
        .mem_data_i      (mem_data_i),
        .if_pc_o         (if_pc_o),
        .if_inst_o       (if_inst_o),
        .if_jmp_status_o (if_jmp_status_o),
        .if_offset_o     (if_offset_o),
        .stallreq_o      (stallreq_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_req(input string tag, input logic [31:0] exp_addr);
        int n = 0;
        while (mem_req_o !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_req"}, {31'd0, mem_req_o}, 32'd1);
        chk({tag, "_addr"}, mem_addr_o, exp_addr);
    endtask

    task automatic complete(input logic [31:0] data);
        mem_done_i = 1'b1;
        mem_data_i = data;
        step();
        mem_done_i = 1'b0;
        mem_data_i = '0;
    endtask

    task automatic serve(input string tag, input logic [31:0] exp_addr, input logic [31:0] data);
        wait_req(tag, exp_addr);
        complete(data);
    endtask

    task automatic br_upd(input logic [31:0] pc, input logic taken);
        ex_br_upd_i   = 1'b1;
        ex_br_pc_i    = pc;
        ex_br_taken_i = taken;
        step();
        ex_br_upd_i   = 1'b0;
        ex_br_pc_i    = '0;
        ex_br_taken_i = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                           input logic taken, input logic [31:0] off);
        chk({tag, "_pc"}, if_pc_o, pc);
        chk({tag, "_inst"}, if_inst_o, inst);
        chk({tag, "_taken"}, {31'd0, if_jmp_status_o}, {31'd0, taken});
        chk({tag, "_off"}, if_offset_o, off);
    endtask

    initial begin
        rst = 1'b1;
        stall_i = '0;
        ex_jmp_wrong_i = 1'b0;
        ex_jmp_target_i = '0;
        ex_br_upd_i = 1'b0;
        ex_br_pc_i = '0;
        ex_br_taken_i = 1'b0;
        mem_done_i = 1'b0;
        mem_data_i = '0;
        step();
        step();

        // Reset state
        chk("rst_req", {31'd0, mem_req_o}, 32'd0);
        chk("rst_stallreq", {31'd0, stallreq_o}, 32'd0);
        chk_out("rst", 32'h0, NOP, 1'b0, 32'h0);

        // First fetch at 0
        rst = 1'b0;
        step();
        chk("f0_req", {31'd0, mem_req_o}, 32'd1);
        chk("f0_addr", mem_addr_o, 32'h0);
        chk("f0_stallreq_busy", {31'd0, stallreq_o}, 32'd1);
        mem_done_i = 1'b1;
        mem_data_i = NOP;
        #1;
        chk("f0_stallreq_done", {31'd0, stallreq_o}, 32'd0);
        step();
        mem_done_i = 1'b0;
        mem_data_i = '0;
        chk_out("f0", 32'h0, NOP, 1'b0, 32'h0);

        serve("f4", 32'h4, NOP);
        chk_out("f4", 32'h4, NOP, 1'b0, 32'h0);

        // JAL +16 at 0x8
        serve("f8", 32'h8, JAL16);
        chk_out("jal", 32'h8, JAL16, 1'b1, 32'd16);

        // Not-taken branch (counter 01) at 0x18
        serve("f18", 32'h18, BEQ8);
        chk_out("bnt", 32'h18, BEQ8, 1'b0, 32'd8);

        // Train the branch at 0x20 twice while 0x1C is in flight
        wait_req("f1c", 32'h1C);
        br_upd(32'h20, 1'b1);
        br_upd(32'h20, 1'b1);
        complete(NOP);

        serve("f20", 32'h20, BEQ32);
        chk_out("bt", 32'h20, BEQ32, 1'b1, 32'd32);

        // Update and lookup of index 16 in the same cycle: old value 01 used
        wait_req("f40", 32'h40);
        ex_br_upd_i   = 1'b1;
        ex_br_pc_i    = 32'h40;
        ex_br_taken_i = 1'b1;
        complete(BEQ8);
        ex_br_upd_i   = 1'b0;
        ex_br_pc_i    = '0;
        ex_br_taken_i = 1'b0;
        chk_out("same_idx", 32'h40, BEQ8, 1'b0, 32'd8);

        // Redirect while BUSY: in-flight data dropped
        wait_req("f44", 32'h44);
        ex_jmp_wrong_i  = 1'b1;
        ex_jmp_target_i = 32'h100;
        step();
        ex_jmp_wrong_i  = 1'b0;
        ex_jmp_target_i = '0;
        chk("disc_req", {31'd0, mem_req_o}, 32'd1);
        chk("disc_stallreq", {31'd0, stallreq_o}, 32'd1);
        mem_done_i = 1'b1;
        mem_data_i = JAL16;
        #1;
        chk("disc_stallreq_done", {31'd0, stallreq_o}, 32'd1);
        step();
        mem_done_i = 1'b0;
        mem_data_i = '0;
        chk("disc_inst", if_inst_o, NOP);
        chk("disc_taken", {31'd0, if_jmp_status_o}, 32'd0);

        // Completion under an IF hold for two cycles goes to the buffer
        wait_req("f100", 32'h100);
        stall_i = 6'b000010;
        complete(ADDI);
        chk("hold1_inst", if_inst_o, NOP);
        chk("hold1_req", {31'd0, mem_req_o}, 32'd0);
        step();
        chk("hold2_inst", if_inst_o, NOP);
        chk("hold2_req", {31'd0, mem_req_o}, 32'd0);
        stall_i = '0;
        step();
        chk_out("buf", 32'h100, ADDI, 1'b0, 32'h0);
        chk("buf_req", {31'd0, mem_req_o}, 32'd0);
        step();
        chk("buf_once", if_inst_o, NOP);
        chk("buf_next_req", {31'd0, mem_req_o}, 32'd1);
        chk("buf_next_addr", mem_addr_o, 32'h104);

        // Completion and redirect together: redirect wins
        mem_done_i      = 1'b1;
        mem_data_i      = JAL16;
        ex_jmp_wrong_i  = 1'b1;
        ex_jmp_target_i = 32'h40;
        step();
        mem_done_i      = 1'b0;
        mem_data_i      = '0;
        ex_jmp_wrong_i  = 1'b0;
        ex_jmp_target_i = '0;
        chk("coin_inst", if_inst_o, NOP);
        chk("coin_taken", {31'd0, if_jmp_status_o}, 32'd0);
        chk("coin_req", {31'd0, mem_req_o}, 32'd0);
        chk("coin_stallreq", {31'd0, stallreq_o}, 32'd0);

        // Counter at 0x20: 11 -> sat 11 -> 11 -> 10, still predicts taken
        wait_req("coin_next", 32'h40);
        br_upd(32'h20, 1'b1);
        br_upd(32'h20, 1'b1);
        br_upd(32'h20, 1'b0);
        complete(ADDI);
        chk_out("f40b", 32'h40, ADDI, 1'b0, 32'h0);

        // Redirect in IDLE: NOP loaded, no request that cycle
        ex_jmp_wrong_i  = 1'b1;
        ex_jmp_target_i = 32'h20;
        step();
        ex_jmp_wrong_i  = 1'b0;
        ex_jmp_target_i = '0;
        chk("idle_redir_req", {31'd0, mem_req_o}, 32'd0);
        chk("idle_redir_inst", if_inst_o, NOP);

        serve("f20b", 32'h20, BEQ32);
        chk_out("sat", 32'h20, BEQ32, 1'b1, 32'd32);

        // PC hold: no request while stall_i[0] is set
        stall_i = 6'b000001;
        step();
        step();
        step();
        chk("pc_hold_req", {31'd0, mem_req_o}, 32'd0);
        stall_i = '0;
        serve("after_hold", 32'h40, NOP);
        chk("end_stallreq", {31'd0, stallreq_o}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 clk  in  1  clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 stall_i  in  6  StallBus; bit0 = PC hold, bit1 = IF hold.
REQ-004 ex_jmp_wrong_i  in  1  EX flags a misprediction this cycle.
REQ-005 ex_jmp_target_i  in  32  correct PC after a misprediction.
REQ-006 ex_br_upd_i  in  1  a branch resolved in EX this cycle.
REQ-007 ex_br_pc_i  in  32  PC of the resolved branch.
REQ-008 ex_br_taken_i  in  1  actual direction of the resolved branch.
REQ-009 mem_req_o  out  1  fetch request to the memory controller, level-held until done.
REQ-010 mem_addr_o  out  32  fetch address; word-aligned.
REQ-011 mem_done_i  in  1  one-cycle pulse; mem_data_i is valid in that cycle.
REQ-012 mem_data_i  in  32  fetched instruction word.
REQ-013 if_pc_o  out  32  PC of the delivered instruction.
REQ-014 if_inst_o  out  32  delivered instruction; NOP 0x00000013 when no instruction is valid.
REQ-015 if_jmp_status_o  out  1  predicted taken.
REQ-016 if_offset_o  out  32  sign-extended B/JAL immediate; 0 for other opcodes.
REQ-017 stallreq_o  out  1  fetch stall request to the stall controller.

Function
REQ-018 FSM states: IDLE, BUSY, DISCARD.
REQ-019 IDLE, stall_i[0]=NoStop, no ex_jmp_wrong_i: assert mem_req_o with mem_addr_o=pc, then go to BUSY.
REQ-020 BUSY: mem_req_o held high and stallreq_o=1 until mem_done_i.
REQ-021 BUSY with mem_done_i: latch mem_data_i into the outputs next edge, go to IDLE, drop stallreq_o the same cycle.
REQ-022 Prediction: opcode 1101111 (JAL) is always taken. Opcode 1100011 (B) is taken when BHT[pc[7:2]][1]=1. Taken gives pc_next=pc+offset; otherwise pc_next=pc+4, modulo 2^32.
REQ-023 BHT: 64 entries of 2-bit saturating counters.
REQ-024 BHT update: on ex_br_upd_i, entry ex_br_pc_i[7:2] increments if taken, decrements otherwise, saturating at 3 and 0.
REQ-025 BHT update and lookup of the same index in one cycle: lookup sees the old value.
REQ-026 ex_jmp_wrong_i in IDLE: pc<=ex_jmp_target_i, the output register loads NOP with if_jmp_status_o=0, and no request is issued that cycle.
REQ-027 ex_jmp_wrong_i in BUSY: pc<=ex_jmp_target_i and go to DISCARD. The controller cannot abort, so mem_req_o stays high.
REQ-028 DISCARD: on mem_done_i drop the data, deliver NOP, go to IDLE; stallreq_o=1 throughout.
REQ-029 A new ex_jmp_wrong_i while in DISCARD overwrites pc; the state does not change.
REQ-030 mem_done_i and ex_jmp_wrong_i in the same cycle: redirect wins, data is dropped, go to IDLE.
REQ-031 stall_i[1]=Stop: output registers hold.
REQ-032 stall_i[0]=Stop: pc holds, no new request is issued, and an in-flight fetch completes.
REQ-033 A completed fetch while stall_i[1]=Stop is kept in a one-entry buffer and delivered when the stall clears.
REQ-034 While the buffer is full, no new fetch is issued.
REQ-035 Latency: request to delivered output = controller latency + 1 cycle.

Reset
REQ-036 rst: pc=0, FSM=IDLE, mem_req_o=0, stallreq_o=0.
REQ-037 rst: if_pc_o=0, if_inst_o=NOP, if_jmp_status_o=0, if_offset_o=0, buffer empty.
REQ-038 rst: all BHT counters = 01 (weak not-taken).
REQ-039 rst during BUSY or DISCARD abandons the fetch. A late mem_done_i arriving in IDLE is ignored.

Structure
REQ-040 The shared defines file holds: StallBus, InstAddrBus, RegBus, True/False, Stop/NoStop, the NOP encoding, opcode constants and the BHT index width.
REQ-041 The BHT is one sub-module, if_bht (sync update, combinational lookup).

Verification
REQ-042 Reset, then a fetch at 0 returns 0x00000013 after 3 cycles: if_pc_o=0, if_jmp_status_o=0, and the next request goes to 0x4.
REQ-043 JAL +16 at pc 0x8: if_jmp_status_o=1, if_offset_o=16, next mem_addr_o=0x18.
REQ-044 Two taken updates to the B-type at 0x20 (counter reaches 3), then refetch: prediction taken, next address 0x20+offset.
REQ-045 ex_jmp_wrong_i with target 0x100 while BUSY: in-flight data dropped, NOP delivered, next mem_addr_o=0x100.
REQ-046 mem_done_i coincides with stall_i[1]=Stop for 2 cycles: outputs hold, then the buffered instruction is delivered once with no duplicate request.
REQ-047 Same-cycle mem_done_i and ex_jmp_wrong_i (target 0x40): no instruction delivered, next request to 0x40.
